lm07_spi_reader: RTL

- Synthesizable SPI initiator that reads one 16-bit temperature frame from an LM07/LM70-family sensor over the 3-wire interface (CS, SCK, SIO).
- Sits between the top-level uio pins and the display/formatting logic.
- Delivers the raw frame, an integer Celsius value and a frame-format error flag.
- Conversions start on request, or periodically when configured.

---
 rtl/lm07_pkg.sv | 25 ++
 rtl/lm07_sck_divider.sv | 32 +++
 rtl/lm07_spi_reader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lm07_pkg.sv
// lm07_pkg: shared constants and types for the LM07/LM70 3-wire SPI reader.
//   - frame width and the five trailing pad bits the sensor drives high
//   - slice indices for the integer and quarter-degree temperature fields
//   - FSM state encoding used by lm07_spi_reader
package lm07_pkg;

  localparam int         LM07_FRAME_BITS   = 16;
  localparam logic [4:0] LM07_PAD_MASK     = 5'h1F;

  // Temperature occupies the top of the frame; the low 5 bits are padding.
  localparam int         LM07_TEMP_MSB     = 15;
  localparam int         LM07_TEMP_INT_LSB = 7;   // [15:7] signed whole degrees
  localparam int         LM07_TEMP_QTR_LSB = 5;   // [15:5] signed quarter degrees
  localparam int         LM07_PAD_MSB      = 4;   // [4:0] padding

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_HOLD,
    ST_GAP
  } lm07_state_e;

endpackage

// File: rtl/lm07_sck_divider.sv
// lm07_sck_divider: half-period timer for the SPI serial clock.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   i_restart    in   hold the counter at zero (asserted while the FSM idles)
//   o_phase_tick out  one-cycle pulse on the last cycle of every CLK_DIV-cycle phase
module lm07_sck_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_phase_tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Every FSM phase lasts exactly CLK_DIV cycles and changes state on the
  // tick, so free-running wrap keeps phases aligned once restart releases.
  always_ff @(posedge clk) begin
    if (rst || i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_phase_tick = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/lm07_spi_reader.sv
// lm07_spi_reader: reads one 16-bit temperature frame from an LM07/LM70 sensor.
//   clk, rst    system clock, synchronous active-high reset
//   start       request a conversion (ignored while busy)
//   spi_cs_n    chip select to sensor, active low
//   spi_sck     serial clock to sensor, idle low
//   spi_sio     serial data from sensor (sensor updates on SCK fall)
//   busy        CS assertion through the CS-high guard time
//   data_valid  one-cycle pulse when raw_data/temp_c/frame_err update
//   raw_data    last complete frame, MSB first
//   temp_c      signed whole degrees C, raw_data[15:7]
//   frame_err   padding bits raw_data[4:0] were not all ones
// With AUTO_PERIOD > 0 a free-running timer also triggers conversions.
module lm07_spi_reader
  import lm07_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int NBITS       = 16,
  parameter int AUTO_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        spi_cs_n,
  output logic        spi_sck,
  input  logic        spi_sio,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] raw_data,
  output logic [8:0]  temp_c,
  output logic        frame_err
);

  localparam int               CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS);

  lm07_state_e                r_state;
  logic                       r_cs_n;
  logic                       r_sck;
  logic                       r_busy;
  logic                       r_dv;
  logic                       r_cooldown;
  logic [CNT_W-1:0]           r_bit_cnt;
  logic [LM07_FRAME_BITS-1:0] r_shift;
  logic [LM07_FRAME_BITS-1:0] r_raw;
  logic [8:0]                 r_temp;
  logic                       r_err;

  logic w_tick;
  logic w_auto_tick;
  logic w_trigger;

  lm07_sck_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk          (clk),
    .rst          (rst),
    .i_restart    (r_state == ST_IDLE),
    .o_phase_tick (w_tick)
  );

  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      localparam int            TW     = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
      localparam logic [TW-1:0] T_LAST = TW'(AUTO_PERIOD - 1);
      logic [TW-1:0] r_timer;

      // Runs regardless of FSM state so triggers stay on a fixed grid.
      always_ff @(posedge clk) begin
        if (rst || (r_timer == T_LAST)) begin
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end
      assign w_auto_tick = (r_timer == T_LAST);
    end else begin : g_no_auto
      assign w_auto_tick = 1'b0;
    end
  endgenerate

  // The first idle cycle after a frame refuses triggers, so a held start
  // yields frames 34*CLK_DIV+2 cycles apart.
  assign w_trigger = (start || w_auto_tick) && !r_cooldown;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cs_n     <= 1'b1;
      r_sck      <= 1'b0;
      r_busy     <= 1'b0;
      r_dv       <= 1'b0;
      r_cooldown <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_raw      <= '0;
      r_temp     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_dv       <= 1'b0;
      r_cooldown <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_cs_n    <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_state   <= ST_SETUP;
          end
        end
        // SIO has been stable for a full phase when SCK rises, so sample here.
        ST_SETUP, ST_SCK_LO: begin
          if (w_tick) begin
            r_sck     <= 1'b1;
            r_shift   <= {r_shift[LM07_FRAME_BITS-2:0], spi_sio};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_state   <= ST_SCK_HI;
          end
        end
        ST_SCK_HI: begin
          if (w_tick) begin
            r_sck   <= 1'b0;
            r_state <= (r_bit_cnt == CNT_LAST) ? ST_HOLD : ST_SCK_LO;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_cs_n  <= 1'b1;
            r_dv    <= 1'b1;
            r_raw   <= r_shift;
            r_temp  <= r_shift[LM07_TEMP_MSB:LM07_TEMP_INT_LSB];
            r_err   <= (r_shift[LM07_PAD_MSB:0] != LM07_PAD_MASK);
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_busy     <= 1'b0;
            r_cooldown <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spi_cs_n   = r_cs_n;
  assign spi_sck    = r_sck;
  assign busy       = r_busy;
  assign data_valid = r_dv;
  assign raw_data   = r_raw;
  assign temp_c     = r_temp;
  assign frame_err  = r_err;

endmodule
